// File: rtl/crossbar_switch_shift_scheduler.sv
// Request-side scheduler for the NxN barrel-shifter crossbar: splits one request batch
// into collision-free single-shift beats. Optional beat counter: CROSSBAR_SCHED_PERF_EN.
module crossbar_switch_shift_scheduler #(
    parameter int N = 8,
    localparam int S = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                batch_valid,
    output logic                batch_ready,
    input  logic [N-1:0]        req_en,
    input  logic [N-1:0][S-1:0] req_sel,
    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [S-1:0]        cfg_shift,
    output logic [N-1:0]        cfg_grant,
    output logic                cfg_last,
    output logic                batch_done,
    output logic [S:0]          perf_beats
);

    typedef enum logic {
        IDLE  = 1'b0,
        SCHED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pend_q, pend_d;
    logic [N-1:0][S-1:0] d_q, d_d, d_new;
    logic [S-1:0]        rr_ptr_q, rr_ptr_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic [S-1:0]        cfg_shift_q, cfg_shift_d;
    logic [N-1:0]        cfg_grant_q, cfg_grant_d;
    logic                cfg_last_q, cfg_last_d;
    logic                batch_done_q, batch_done_d;

    logic                accept;
    logic                hs;
    logic [N-1:0]        pk_pend;
    logic [N-1:0][S-1:0] pk_d;
    logic [S-1:0]        pk_ptr;
    logic [S-1:0]        pk_shift;
    logic [N-1:0]        pk_grant;
    logic                pk_last;

    assign batch_ready = (state_q == IDLE);
    assign accept      = batch_valid & batch_ready;
    assign hs          = cfg_valid_q & cfg_ready;

    assign cfg_valid   = cfg_valid_q;
    assign cfg_shift   = cfg_shift_q;
    assign cfg_grant   = cfg_grant_q;
    assign cfg_last    = cfg_last_q;
    assign batch_done  = batch_done_q;

    // Required rotation per output: output j sees input (j+s) mod N.
    always_comb begin
        d_new = '0;
        for (int j = 0; j < N; j++) begin
            d_new[j] = req_sel[j] - S'(j);
        end
    end

    // The beat picker serves both the first beat (from the incoming batch) and
    // every follow-on beat (from what remains after the current grant), so the
    // next beat is always ready to register at the handshake edge.
    always_comb begin
        if (state_q == IDLE) begin
            pk_pend = req_en;
            pk_d    = d_new;
            pk_ptr  = rr_ptr_q;
        end else begin
            pk_pend = pend_q & ~cfg_grant_q;
            pk_d    = d_q;
            pk_ptr  = cfg_shift_q + S'(1);
        end
    end

    always_comb begin
        logic         found;
        logic [S-1:0] cand;
        logic [N-1:0] hit;
        found    = 1'b0;
        cand     = '0;
        hit      = '0;
        pk_shift = pk_ptr;
        pk_grant = '0;
        for (int k = 0; k < N; k++) begin
            cand = pk_ptr + S'(k);
            for (int j = 0; j < N; j++) begin
                hit[j] = pk_pend[j] & (pk_d[j] == cand);
            end
            if (!found && (|hit)) begin
                found    = 1'b1;
                pk_shift = cand;
                pk_grant = hit;
            end
        end
    end

    assign pk_last = (pk_grant == pk_pend);

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        d_d          = d_q;
        rr_ptr_d     = rr_ptr_q;
        cfg_valid_d  = cfg_valid_q;
        cfg_shift_d  = cfg_shift_q;
        cfg_grant_d  = cfg_grant_q;
        cfg_last_d   = cfg_last_q;
        batch_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    d_d    = d_new;
                    pend_d = req_en;
                    if (|req_en) begin
                        state_d     = SCHED;
                        cfg_valid_d = 1'b1;
                        cfg_shift_d = pk_shift;
                        cfg_grant_d = pk_grant;
                        cfg_last_d  = pk_last;
                    end else begin
                        batch_done_d = 1'b1;
                    end
                end
            end
            SCHED: begin
                if (hs) begin
                    pend_d   = pk_pend;
                    rr_ptr_d = cfg_shift_q + S'(1);
                    if (cfg_last_q) begin
                        state_d      = IDLE;
                        cfg_valid_d  = 1'b0;
                        cfg_grant_d  = '0;
                        cfg_last_d   = 1'b0;
                        batch_done_d = 1'b1;
                    end else begin
                        cfg_shift_d = pk_shift;
                        cfg_grant_d = pk_grant;
                        cfg_last_d  = pk_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            rr_ptr_q     <= '0;
            cfg_valid_q  <= 1'b0;
            cfg_shift_q  <= '0;
            cfg_grant_q  <= '0;
            cfg_last_q   <= 1'b0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            rr_ptr_q     <= rr_ptr_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_grant_q  <= cfg_grant_d;
            cfg_last_q   <= cfg_last_d;
            batch_done_q <= batch_done_d;
        end
    end

    // Shift table is qualified by pend, so it needs no reset.
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

`ifdef CROSSBAR_SCHED_PERF_EN
    logic [S:0] beat_cnt_q, beat_cnt_d;
    logic [S:0] perf_q, perf_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        perf_d     = perf_q;
        if (accept) begin
            beat_cnt_d = '0;
            if (req_en == '0) begin
                perf_d = '0;
            end
        end else if (hs) begin
            beat_cnt_d = beat_cnt_q + (S+1)'(1);
            if (cfg_last_q) begin
                perf_d = beat_cnt_q + (S+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            perf_q     <= perf_d;
        end
    end

    assign perf_beats = perf_q;
`else
    assign perf_beats = '0;
`endif

endmodule
